// File: rtl/status_jump_unit.sv
// Program-counter / status-register unit: conditional jumps on forwarded ALU flags,
// status-register load/xor, and a trap mode that blocks instruction issue until acknowledged.
module status_jump_unit #(
    parameter logic [19:0] RESET_PC    = 20'h00000,
    parameter logic [19:0] TRAP_VECTOR = 20'h000F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [19:0] operand,
    input  logic        flag_we,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_carry,
    input  logic        trap_ack,
    output logic [19:0] pc,
    output logic [3:0]  sr,
    output logic        out_valid,
    output logic        taken,
    output logic        trap_active
);

    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpJmp   = 3'b001;
    localparam logic [2:0] OpJz    = 3'b010;
    localparam logic [2:0] OpJs    = 3'b011;
    localparam logic [2:0] OpJzs   = 3'b100;
    localparam logic [2:0] OpLdsr  = 3'b101;
    localparam logic [2:0] OpXorsr = 3'b110;
    localparam logic [2:0] OpTrap  = 3'b111;

    typedef enum logic [0:0] {StRun, StTrap} state_e;

    state_e      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic [3:0]  sr_q, sr_d;
    logic        taken_q, taken_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        eff_z, eff_s;
    logic [19:0] pc_inc;

    assign in_ready    = (state_q == StRun);
    assign trap_active = (state_q == StTrap);
    assign accept      = in_valid & in_ready;
    assign pc_inc      = pc_q + 20'd1;

    // Flags written this cycle are forwarded straight into the jump decision.
    assign eff_z = flag_we ? alu_zero : sr_q[0];
    assign eff_s = flag_we ? alu_sign : sr_q[1];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sr_d        = sr_q;
        taken_d     = taken_q;
        out_valid_d = accept;

        if (flag_we) begin
            sr_d[2:0] = {alu_carry, alu_sign, alu_zero};
        end

        if (accept) begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
            unique case (op)
                OpNop: ;
                OpJmp: begin
                    pc_d    = operand;
                    taken_d = 1'b1;
                end
                OpJz: begin
                    if (eff_z) begin
                        pc_d    = operand;
                        taken_d = 1'b1;
                    end
                end
                OpJs: begin
                    if (eff_s) begin
                        pc_d    = operand;
                        taken_d = 1'b1;
                    end
                end
                OpJzs: begin
                    if (eff_z | eff_s) begin
                        pc_d    = operand;
                        taken_d = 1'b1;
                    end
                end
                OpLdsr:  sr_d[2:0] = operand[2:0];
                OpXorsr: sr_d[2:0] = sr_q[2:0] ^ operand[2:0];
                OpTrap: begin
                    pc_d    = TRAP_VECTOR;
                    sr_d[3] = 1'b1;
                    taken_d = 1'b1;
                    state_d = StTrap;
                end
                default: ;
            endcase
        end

        if (state_q == StTrap && trap_ack) begin
            state_d = StRun;
            sr_d[3] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            sr_q        <= 4'b0000;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sr_q        <= sr_d;
            taken_q     <= taken_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pc        = pc_q;
    assign sr        = sr_q;
    assign taken     = taken_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_status_jump_unit.sv
// Directed bench for status_jump_unit: expected results are queued at issue time
// and compared when the out_valid pulse arrives.
module tb_status_jump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [19:0] operand;
    logic        flag_we;
    logic        alu_zero, alu_sign, alu_carry;
    logic        trap_ack;
    logic [19:0] pc;
    logic [3:0]  sr;
    logic        out_valid;
    logic        taken;
    logic        trap_active;

    typedef struct packed {
        logic [19:0] pc;
        logic [3:0]  sr;
        logic        taken;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [2:0] NOP = 3'b000, JMP = 3'b001, JZ = 3'b010, JS = 3'b011,
                           JZS = 3'b100, LDSR = 3'b101, XORSR = 3'b110, TRAP = 3'b111;

    status_jump_unit #(
        .RESET_PC   (20'h00000),
        .TRAP_VECTOR(20'h000F0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand    (operand),
        .flag_we    (flag_we),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .alu_carry  (alu_carry),
        .trap_ack   (trap_ack),
        .pc         (pc),
        .sr         (sr),
        .out_valid  (out_valid),
        .taken      (taken),
        .trap_active(trap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue the expectation if acceptance is expected, then check.
    task automatic step(input logic v, input logic [2:0] o, input logic [19:0] opnd,
                        input logic fwe, input logic [2:0] csz, input logic ack,
                        input logic acc, input logic [19:0] epc, input logic [3:0] esr,
                        input logic etk);
        exp_t e;
        in_valid = v;
        op       = o;
        operand  = opnd;
        flag_we  = fwe;
        {alu_carry, alu_sign, alu_zero} = csz;
        trap_ack = ack;
        if (acc) sb.push_back('{pc: epc, sr: esr, taken: etk});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flag_we  = 1'b0;
        trap_ack = 1'b0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, acc});
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pc", {12'd0, pc}, {12'd0, e.pc});
                chk("sr", {28'd0, sr}, {28'd0, e.sr});
                chk("taken", {31'd0, taken}, {31'd0, e.taken});
            end
        end else begin
            chk("pc_hold", {12'd0, pc}, {12'd0, epc});
            chk("sr_hold", {28'd0, sr}, {28'd0, esr});
        end
    endtask

    task automatic chk_mode(input logic exp_trap);
        chk("trap_active", {31'd0, trap_active}, {31'd0, exp_trap});
        chk("in_ready", {31'd0, in_ready}, {31'd0, ~exp_trap});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = NOP; operand = '0; flag_we = 1'b0;
        alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0; trap_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pc", {12'd0, pc}, 32'h0);
        chk("rst_sr", {28'd0, sr}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_taken", {31'd0, taken}, 32'h0);
        chk_mode(1'b0);

        // NOP x3
        step(1, NOP, 20'h0, 0, 3'b000, 0, 1, 20'h00001, 4'b0000, 0);
        step(1, NOP, 20'h0, 0, 3'b000, 0, 1, 20'h00002, 4'b0000, 0);
        step(1, NOP, 20'h0, 0, 3'b000, 0, 1, 20'h00003, 4'b0000, 0);
        // JZ with forwarded Z, then JS with S=0
        step(1, JZ,  20'h00400, 1, 3'b001, 0, 1, 20'h00400, 4'b0001, 1);
        step(1, JS,  20'h00777, 0, 3'b000, 0, 1, 20'h00401, 4'b0001, 0);
        // LDSR beats simultaneous flag write; operand[3] ignored
        step(1, LDSR,  20'h0000F, 1, 3'b000, 0, 1, 20'h00402, 4'b0111, 0);
        step(1, XORSR, 20'h00005, 0, 3'b000, 0, 1, 20'h00403, 4'b0010, 0);
        // JZS taken on stored S
        step(1, JZS, 20'h00500, 0, 3'b000, 0, 1, 20'h00500, 4'b0010, 1);
        // flag write with no instruction
        step(0, JMP, 20'h12345, 1, 3'b100, 0, 0, 20'h00500, 4'b0100, 0);
        step(1, JZ,  20'h00600, 0, 3'b000, 0, 1, 20'h00501, 4'b0100, 0);
        // wrap-around
        step(1, JMP, 20'hFFFFF, 0, 3'b000, 0, 1, 20'hFFFFF, 4'b0100, 1);
        step(1, NOP, 20'h0,     0, 3'b000, 0, 1, 20'h00000, 4'b0100, 0);
        step(0, NOP, 20'h0,     0, 3'b000, 0, 0, 20'h00000, 4'b0100, 0);
        // TRAP: JMP ignored for 3 cycles, flag write still applies
        step(1, TRAP, 20'h0,    0, 3'b000, 0, 1, 20'h000F0, 4'b1100, 1);
        chk_mode(1'b1);
        step(1, JMP, 20'h00123, 0, 3'b000, 0, 0, 20'h000F0, 4'b1100, 0);
        step(1, JMP, 20'h00123, 1, 3'b001, 0, 0, 20'h000F0, 4'b1001, 0);
        step(1, JMP, 20'h00123, 0, 3'b000, 0, 0, 20'h000F0, 4'b1001, 0);
        chk_mode(1'b1);
        step(0, NOP, 20'h0, 0, 3'b000, 1, 0, 20'h000F0, 4'b0001, 0);
        chk_mode(1'b0);
        // trap_ack in RUN has no effect
        step(0, NOP, 20'h0, 0, 3'b000, 1, 0, 20'h000F0, 4'b0001, 0);
        chk_mode(1'b0);
        // back-to-back pulses
        step(1, JMP, 20'h00010, 0, 3'b000, 0, 1, 20'h00010, 4'b0001, 1);
        step(1, NOP, 20'h0,     0, 3'b000, 0, 1, 20'h00011, 4'b0001, 0);
        // reset while in TRAP, with an instruction presented at the reset edge
        step(1, TRAP, 20'h0, 0, 3'b000, 0, 1, 20'h000F0, 4'b1001, 1);
        rst = 1'b1;
        in_valid = 1'b1; op = JMP; operand = 20'h00ABC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("trst_pc", {12'd0, pc}, 32'h0);
        chk("trst_sr", {28'd0, sr}, 32'h0);
        chk("trst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("trst_taken", {31'd0, taken}, 32'h0);
        chk_mode(1'b0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
